// File: rtl/usib_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usib_pkg
//  Description : Shared definitions for the USIB master arbiter: command
//                codes, UsiAdrs field positions, arbiter FSM encoding and a
//                small width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package usib_pkg;

    // Command codes carried in UsiAdrs[31:30] and on the requester cmd lanes
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_WRRD = 2'b11;

    // UsiAdrs field positions
    localparam int CMD_MSB = 31;
    localparam int CMD_LSB = 30;
    localparam int BLK_MSB = 19;
    localparam int BLK_LSB = 16;
    localparam int CSR_MSB = 15;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    // Index/counter width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usib_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : usib_master_arbiter_if
//  Description : Requester-side and bus-side signal bundle of the USIB master
//                arbiter. The master modport is the arbiter's view; the slave
//                modport is the view of the requesters and bus fabric.
//  Revision    : 1.0  initial release
// ============================================================================
interface usib_master_arbiter_if
    import usib_pkg::*;
#(
    parameter int pReqNum       = 3,
    parameter int pUsiBusWidth  = 32,
    parameter int pReqAdrsWidth = 20
);
    logic [2*pReqNum-1:0]             iReqCmd;
    logic [pReqAdrsWidth*pReqNum-1:0] iReqAdrs;
    logic [pUsiBusWidth*pReqNum-1:0]  iReqWd;
    logic [pReqNum-1:0]               oReqAck;
    logic [pUsiBusWidth-1:0]          oReqRd;
    logic                             oBusy;
    logic [pUsiBusWidth-1:0]          oMUsiAdrs;
    logic [pUsiBusWidth-1:0]          oMUsiWd;
    logic [pUsiBusWidth-1:0]          iMUsiRd;

    modport master (
        input  iReqCmd, iReqAdrs, iReqWd, iMUsiRd,
        output oReqAck, oReqRd, oBusy, oMUsiAdrs, oMUsiWd
    );

    modport slave (
        output iReqCmd, iReqAdrs, iReqWd, iMUsiRd,
        input  oReqAck, oReqRd, oBusy, oMUsiAdrs, oMUsiWd
    );
endinterface
`default_nettype wire

// File: rtl/usib_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : usib_rr_select
//  Description : Combinational winner selection. Searches the request vector
//                starting at the round-robin pointer and returns a one-hot
//                grant plus its index. With USIB_ARB_FIXED_PRIO_EN defined the
//                search always starts at index 0 (lowest index wins).
//  Revision    : 1.0  initial release
// ============================================================================
module usib_rr_select
    import usib_pkg::*;
#(
    parameter int pReqNum   = 3,
    parameter int pIdxWidth = clog2_min1(pReqNum)
) (
    input  logic [pReqNum-1:0]   req_i,
    input  logic [pIdxWidth-1:0] ptr_i,
    output logic [pReqNum-1:0]   grant_o,
    output logic [pIdxWidth-1:0] idx_o,
    output logic                 valid_o
);
    int start_w;

`ifdef USIB_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
    assign start_w    = 0;
`else
    assign start_w    = int'(ptr_i);
`endif

    // First requester found walking upward from the start index, with wrap
    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < pReqNum; k++) begin
            j = start_w + k;
            if (j >= pReqNum) begin
                j = j - pReqNum;
            end
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = pIdxWidth'(j);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/usib_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usib_master_arbiter
//  Description : Shares the single USIB bus master port between pReqNum
//                requesters. One CSR transaction at a time: grant, one ISSUE
//                cycle carrying the full UsiAdrs word, a fixed read-latency
//                wait (block ID kept live for the read mux), then a one-cycle
//                ack with the captured read data.
//                Build option: USIB_ARB_FIXED_PRIO_EN selects fixed priority
//                (lowest index wins) instead of round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
module usib_master_arbiter
    import usib_pkg::*;
#(
    parameter int pReqNum       = 3,
    parameter int pUsiBusWidth  = 32,
    parameter int pCsrAdrsWidth = 16,
    parameter int pBlkIdWidth   = 4,
    parameter int pRdLatency    = 3
) (
    input  logic                  iSCLK,
    input  logic                  iSRST,
    usib_master_arbiter_if.master bus_if
);
    localparam int pReqAdrsWidth = pBlkIdWidth + pCsrAdrsWidth;
    localparam int IDX_W         = clog2_min1(pReqNum);
    localparam int CNT_W         = clog2_min1(pRdLatency);

    // Compose a UsiAdrs word from its fields; all other bits are zero
    function automatic logic [pUsiBusWidth-1:0] usi_adrs(
        input logic [1:0]               cmd,
        input logic [pBlkIdWidth-1:0]   blk,
        input logic [pCsrAdrsWidth-1:0] csr
    );
        logic [pUsiBusWidth-1:0] a;
        a                        = '0;
        a[CMD_MSB:CMD_LSB]       = cmd;
        a[BLK_LSB +: pBlkIdWidth] = blk;
        a[0 +: pCsrAdrsWidth]    = csr;
        return a;
    endfunction

    logic [pReqNum-1:0]       req_w;
    logic [pReqNum-1:0]       sel_grant;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_valid;
    logic [IDX_W-1:0]         rr_ptr;
    logic [1:0]               win_cmd;
    logic [pReqAdrsWidth-1:0] win_adrs;
    logic [pUsiBusWidth-1:0]  win_wd;

    arb_state_t               state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [pReqNum-1:0]       grant_q;
    logic [1:0]               cmd_q;
    logic [pBlkIdWidth-1:0]   blk_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [pReqNum-1:0]       ack_q;
    logic [pUsiBusWidth-1:0]  rd_q;
    logic                     busy_q;
    logic [pUsiBusWidth-1:0]  madrs_q;
    logic [pUsiBusWidth-1:0]  mwd_q;

    // Any non-zero command lane is a request
    always_comb begin
        req_w = '0;
        for (int i = 0; i < pReqNum; i++) begin
            req_w[i] = |bus_if.iReqCmd[2*i +: 2];
        end
    end

    usib_rr_select #(
        .pReqNum   (pReqNum),
        .pIdxWidth (IDX_W)
    ) u_sel (
        .req_i   (req_w),
        .ptr_i   (rr_ptr),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign win_cmd  = bus_if.iReqCmd[int'(sel_idx)*2 +: 2];
    assign win_adrs = bus_if.iReqAdrs[int'(sel_idx)*pReqAdrsWidth +: pReqAdrsWidth];
    assign win_wd   = bus_if.iReqWd[int'(sel_idx)*pUsiBusWidth +: pUsiBusWidth];

`ifdef USIB_ARB_FIXED_PRIO_EN
    logic unused_idx;
    assign unused_idx = ^idx_q;
    assign rr_ptr     = '0;
`else
    logic [IDX_W-1:0] ptr_q;

    // Round-robin pointer moves past the requester acknowledged this cycle
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            ptr_q <= '0;
        end else if (state_q == ST_ACK) begin
            ptr_q <= (idx_q == IDX_W'(pReqNum-1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign rr_ptr = ptr_q;
`endif

    // Transaction FSM; every bus and requester output is registered here
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            cmd_q   <= CMD_NONE;
            blk_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            madrs_q <= '0;
            mwd_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        idx_q   <= sel_idx;
                        grant_q <= sel_grant;
                        cmd_q   <= win_cmd;
                        blk_q   <= win_adrs[pReqAdrsWidth-1 -: pBlkIdWidth];
                        madrs_q <= usi_adrs(win_cmd,
                                            win_adrs[pReqAdrsWidth-1 -: pBlkIdWidth],
                                            win_adrs[pCsrAdrsWidth-1:0]);
                        mwd_q   <= win_wd;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_q == CMD_WR) begin
                        madrs_q <= '0;
                        ack_q   <= grant_q;
                        state_q <= ST_ACK;
                    end else begin
                        // Command bits drop so no slave re-executes; block ID
                        // stays so the read mux keeps selecting this slave.
                        madrs_q <= usi_adrs(CMD_NONE, blk_q, '0);
                        cnt_q   <= CNT_W'(pRdLatency-1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rd_q    <= bus_if.iMUsiRd;
                        madrs_q <= '0;
                        ack_q   <= grant_q;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.oReqAck   = ack_q;
    assign bus_if.oReqRd    = rd_q;
    assign bus_if.oBusy     = busy_q;
    assign bus_if.oMUsiAdrs = madrs_q;
    assign bus_if.oMUsiWd   = mwd_q;
endmodule
`default_nettype wire

// File: tb/tb_usib_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usib_master_arbiter
//  Description : Directed self-checking bench for usib_master_arbiter with a
//                three-stage bus read model (data valid three cycles after the
//                read address cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usib_master_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    usib_master_arbiter_if #(
        .pReqNum       (3),
        .pUsiBusWidth  (32),
        .pReqAdrsWidth (20)
    ) bus_if ();

    usib_master_arbiter #(
        .pReqNum       (3),
        .pUsiBusWidth  (32),
        .pCsrAdrsWidth (16),
        .pBlkIdWidth   (4),
        .pRdLatency    (3)
    ) dut (
        .iSCLK  (clk),
        .iSRST  (rst),
        .bus_if (bus_if)
    );

    // Slave read values: one fixed pattern, otherwise derived from the address
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a[19:0] == 20'h1_0004) return 32'h1234_5678;
        return {12'hABC, a[19:0]};
    endfunction

    logic [31:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1          <= bus_if.oMUsiAdrs[31] ? rd_val(bus_if.oMUsiAdrs) : 32'h0;
        pipe2          <= pipe1;
        bus_if.iMUsiRd <= pipe2;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [1:0] cmd, input logic [19:0] adrs,
                           input logic [31:0] wd);
        bus_if.iReqCmd[r*2 +: 2]   = cmd;
        bus_if.iReqAdrs[r*20 +: 20] = adrs;
        bus_if.iReqWd[r*32 +: 32]  = wd;
    endtask

    // One transaction from an idle arbiter, checked cycle by cycle
    task automatic do_txn(input string tag, input int r, input logic [1:0] cmd,
                          input logic [19:0] adrs, input logic [31:0] wd,
                          input logic [31:0] exp_issue, input logic [31:0] exp_wait,
                          input int n_wait, input logic [2:0] exp_ack,
                          input logic [31:0] exp_rd);
        set_req(r, cmd, adrs, wd);
        step(1);
        check({tag, "_issue_adrs"}, bus_if.oMUsiAdrs, exp_issue);
        check({tag, "_issue_wd"},   bus_if.oMUsiWd, wd);
        check({tag, "_issue_busy"}, 32'(bus_if.oBusy), 32'd1);
        for (int k = 0; k < n_wait; k++) begin
            step(1);
            check({tag, "_wait_adrs"}, bus_if.oMUsiAdrs, exp_wait);
            check({tag, "_wait_ack"},  32'(bus_if.oReqAck), 32'd0);
        end
        step(1);
        check({tag, "_ack"},      32'(bus_if.oReqAck), 32'(exp_ack));
        check({tag, "_ack_rd"},   bus_if.oReqRd, exp_rd);
        check({tag, "_ack_adrs"}, bus_if.oMUsiAdrs, 32'h0);
        check({tag, "_ack_busy"}, 32'(bus_if.oBusy), 32'd1);
        set_req(r, 2'b00, 20'h0, 32'h0);
        step(1);
        check({tag, "_done_ack"},  32'(bus_if.oReqAck), 32'd0);
        check({tag, "_done_busy"}, 32'(bus_if.oBusy), 32'd0);
    endtask

    task automatic wait_ack(output logic [2:0] ack, output int n);
        n   = 0;
        ack = '0;
        while (n < 20) begin
            step(1);
            n++;
            if (bus_if.oReqAck != 3'b000) begin
                ack = bus_if.oReqAck;
                break;
            end
        end
    endtask

    logic [2:0]  exp_seq [4];
    logic [31:0] exp_rds [4];
    logic [31:0] exp_rst_issue;
    logic [2:0]  got_ack;
    int          got_n;

    initial begin
`ifdef USIB_ARB_FIXED_PRIO_EN
        exp_seq       = '{3'b001, 3'b001, 3'b001, 3'b001};
        exp_rds       = '{32'hABC0_0100, 32'hABC0_0100, 32'hABC0_0100, 32'hABC0_0100};
        exp_rst_issue = 32'h8001_0040;
`else
        exp_seq       = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rds       = '{32'hABC0_0100, 32'hABC1_0200, 32'hABC2_0300, 32'hABC0_0100};
        exp_rst_issue = 32'h8002_0080;
`endif
        bus_if.iReqCmd  = '0;
        bus_if.iReqAdrs = '0;
        bus_if.iReqWd   = '0;
        rst = 1'b1;
        step(3);
        check("rst_adrs", bus_if.oMUsiAdrs, 32'h0);
        check("rst_wd",   bus_if.oMUsiWd, 32'h0);
        check("rst_ack",  32'(bus_if.oReqAck), 32'd0);
        check("rst_rd",   bus_if.oReqRd, 32'h0);
        check("rst_busy", 32'(bus_if.oBusy), 32'd0);
        rst = 1'b0;
        step(1);

        // Directed transactions; pointer walks 0->1->2->0->1->2
        do_txn("wr0",   0, 2'b01, 20'h2_0010, 32'hDEAD_BEEF, 32'h4002_0010, 32'h0,          0, 3'b001, 32'h0);
        do_txn("rd1",   1, 2'b10, 20'h1_0004, 32'h0000_0000, 32'h8001_0004, 32'h0001_0000, 3, 3'b010, 32'h1234_5678);
        do_txn("wrrd2", 2, 2'b11, 20'h3_00FF, 32'h55AA_55AA, 32'hC003_00FF, 32'h0003_0000, 3, 3'b100, 32'hABC3_00FF);
        do_txn("wr0b",  0, 2'b01, 20'h0_0020, 32'h0BAD_F00D, 32'h4000_0020, 32'h0,          0, 3'b001, 32'hABC3_00FF);
        do_txn("rd1b",  1, 2'b10, 20'h1_0008, 32'h0000_0000, 32'h8001_0008, 32'h0001_0000, 3, 3'b010, 32'hABC1_0008);

        // Reset during WAIT; pending requests re-arbitrate from pointer 0
        set_req(1, 2'b10, 20'h1_0040, 32'h0);
        set_req(2, 2'b10, 20'h2_0080, 32'h0);
        step(1);
        check("rstw_issue_adrs", bus_if.oMUsiAdrs, exp_rst_issue);
        step(1);
        rst = 1'b1;
        step(1);
        check("rstw_adrs", bus_if.oMUsiAdrs, 32'h0);
        check("rstw_busy", 32'(bus_if.oBusy), 32'd0);
        check("rstw_ack",  32'(bus_if.oReqAck), 32'd0);
        rst = 1'b0;
        step(1);
        check("regrant_adrs", bus_if.oMUsiAdrs, 32'h8001_0040);
        step(3);
        check("regrant_wait_ack", 32'(bus_if.oReqAck), 32'd0);
        step(1);
        check("regrant_ack", 32'(bus_if.oReqAck), 32'b010);
        check("regrant_rd",  bus_if.oReqRd, 32'hABC1_0040);
        set_req(1, 2'b00, 20'h0, 32'h0);
        set_req(2, 2'b00, 20'h0, 32'h0);
        step(2);

        // Continuous reads on all requesters from a fresh pointer
        rst = 1'b1;
        set_req(0, 2'b10, 20'h0_0100, 32'h0);
        set_req(1, 2'b10, 20'h1_0200, 32'h0);
        set_req(2, 2'b10, 20'h2_0300, 32'h0);
        step(1);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_ack(got_ack, got_n);
            check($sformatf("cont%0d_ack", t), 32'(got_ack), 32'(exp_seq[t]));
            check($sformatf("cont%0d_rd", t), bus_if.oReqRd, exp_rds[t]);
            check($sformatf("cont%0d_gap", t), 32'(got_n), (t == 0) ? 32'd5 : 32'd6);
        end
        bus_if.iReqCmd = '0;
        step(3);
        check("end_busy", 32'(bus_if.oBusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
